// File: rtl/decoder_scan_pkg.sv
// Shared types for the LED decoder scan controller: mode encodings,
// ping-pong direction constants and the mode sequencing helper.
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL    = 2'd0,
        MODE_SCAN_UP   = 2'd1,
        MODE_SCAN_DOWN = 2'd2,
        MODE_PING_PONG = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_MANUAL:    return MODE_SCAN_UP;
            MODE_SCAN_UP:   return MODE_SCAN_DOWN;
            MODE_SCAN_DOWN: return MODE_PING_PONG;
            default:        return MODE_MANUAL;
        endcase
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output only
// follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          meta;
    logic          synced;
    logic [CW-1:0] cnt;

    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            cnt    <= '0;
            dout   <= 1'b0;
        end else begin
            meta   <= din;
            synced <= meta;
            if (synced == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                dout <= synced;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Drives the 2-bit LED decoder select either from debounced switches or
// from a prescaled auto-scan (up, down, ping-pong) chosen by the mode button.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int TICK_DIV        = 12000000,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       mode_btn,
    output logic [1:0] sel,
    output logic [1:0] mode,
    output logic       step
);

    localparam int PW = $clog2(TICK_DIV);

    logic [1:0]    sw_db;
    logic          btn_db;
    logic          btn_q;
    logic          btn_press;

    mode_e         mode_q, mode_d;
    logic [1:0]    sel_q, sel_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          dir_q, dir_d;
    logic          step_q, step_d;

    logic          tick;
    logic          pp_dir;
    logic [1:0]    pp_next;
    logic          pp_dir_next;

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw0 (
        .clk(clk), .rst(rst), .din(sw[0]), .dout(sw_db[0])
    );
    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw1 (
        .clk(clk), .rst(rst), .din(sw[1]), .dout(sw_db[1])
    );
    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .clk(clk), .rst(rst), .din(mode_btn), .dout(btn_db)
    );

    assign btn_press = btn_db & ~btn_q;
    assign tick      = (presc_q == PW'(TICK_DIV - 1));

    // At the ends of the range the bounce direction is forced, so entering
    // ping-pong at 3 heads down regardless of the stored direction.
    assign pp_dir      = (sel_q == 2'd3) ? DIR_DOWN :
                         (sel_q == 2'd0) ? DIR_UP   : dir_q;
    assign pp_next     = (pp_dir == DIR_UP) ? sel_q + 2'd1 : sel_q - 2'd1;
    assign pp_dir_next = (pp_next == 2'd3) ? DIR_DOWN :
                         (pp_next == 2'd0) ? DIR_UP   : pp_dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q   <= 1'b0;
            mode_q  <= MODE_MANUAL;
            sel_q   <= 2'd0;
            presc_q <= '0;
            dir_q   <= DIR_UP;
            step_q  <= 1'b0;
        end else begin
            btn_q   <= btn_db;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        mode_d  = mode_q;
        sel_d   = sel_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        step_d  = 1'b0;

        if (btn_press) begin
            // A mode change beats a coincident tick: sel holds, no step.
            mode_d  = next_mode(mode_q);
            presc_d = '0;
            dir_d   = DIR_UP;
        end else if (mode_q == MODE_MANUAL) begin
            sel_d   = sw_db;
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
            step_d  = 1'b1;
            case (mode_q)
                MODE_SCAN_UP:   sel_d = sel_q + 2'd1;
                MODE_SCAN_DOWN: sel_d = sel_q - 2'd1;
                MODE_PING_PONG: begin
                    sel_d = pp_next;
                    dir_d = pp_dir_next;
                end
                default:        sel_d = sel_q;
            endcase
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    assign sel  = sel_q;
    assign mode = mode_q;
    assign step = step_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3:
// expected step events are queued at stimulus time and matched by a monitor.
module tb_decoder_scan_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;

    typedef struct {
        logic [1:0] sel;
        int         cyc;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [1:0] sw       = 2'b00;
    logic       mode_btn = 1'b0;
    logic [1:0] sel;
    logic [1:0] mode;
    logic       step;

    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    int   m_up, m_down, m_pp;

    decoder_scan_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .sw(sw), .mode_btn(mode_btn),
        .sel(sel), .mode(mode), .step(step)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every observed step pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (step === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_step cycle=%0d sel=%0d: got step=1, required no step", cyc, sel);
            end else begin
                e = exp_q.pop_front();
                if (sel !== e.sel || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL step_event: got sel=%0d at cycle %0d, required sel=%0d at cycle %0d",
                             sel, cyc, e.sel, e.cyc);
                end
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) wait_edges(1);
    endtask

    task automatic push_step(input logic [1:0] s, input int e);
        exp_t x;
        x.sel = s;
        x.cyc = e;
        exp_q.push_back(x);
    endtask

    // Clean press: accepted 5 edges after drive, mode changes on the 6th.
    task automatic press(output int m_edge);
        int b;
        b        = cyc;
        mode_btn = 1'b1;
        wait_edges(6);
        mode_btn = 1'b0;
        m_edge   = b + 6;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_edges(2);
        vectors++;
        if (sel !== 2'd0) begin miscompares++; $display("FAIL reset_sel: got %0d, required 0", sel); end
        vectors++;
        if (mode !== 2'd0) begin miscompares++; $display("FAIL reset_mode: got %0d, required 0", mode); end
        vectors++;
        if (step !== 1'b0) begin miscompares++; $display("FAIL reset_step: got %0d, required 0", step); end
        rst = 1'b0;
    endtask

    task automatic test_manual();
        int s;
        s  = cyc;
        sw = 2'b10;
        wait_until(s + 5);
        vectors++;
        if (sel !== 2'd0) begin miscompares++; $display("FAIL manual_early: got sel=%0d, required 0", sel); end
        wait_edges(1);
        vectors++;
        if (sel !== 2'd2) begin miscompares++; $display("FAIL manual_latency: got sel=%0d, required 2", sel); end
        vectors++;
        if (mode !== 2'd0) begin miscompares++; $display("FAIL manual_mode: got %0d, required 0", mode); end
    endtask

    task automatic test_glitch();
        int g;
        sw = 2'b00;
        wait_edges(8);
        vectors++;
        if (sel !== 2'd0) begin miscompares++; $display("FAIL glitch_base: got sel=%0d, required 0", sel); end
        sw = 2'b01;
        wait_edges(2);
        sw = 2'b00;
        wait_edges(8);
        vectors++;
        if (sel !== 2'd0) begin miscompares++; $display("FAIL glitch_reject: got sel=%0d, required 0", sel); end
        g  = cyc;
        sw = 2'b01;
        wait_until(g + 5);
        vectors++;
        if (sel !== 2'd0) begin miscompares++; $display("FAIL glitch_hold_early: got sel=%0d, required 0", sel); end
        wait_edges(1);
        vectors++;
        if (sel !== 2'd1) begin miscompares++; $display("FAIL glitch_accept: got sel=%0d, required 1", sel); end
    endtask

    task automatic test_scan_up();
        int b;
        sw = 2'b10;
        wait_edges(8);
        vectors++;
        if (sel !== 2'd2) begin miscompares++; $display("FAIL scan_up_start: got sel=%0d, required 2", sel); end
        b = cyc;
        push_step(2'd3, b + 10);
        push_step(2'd0, b + 14);
        push_step(2'd1, b + 18);
        push_step(2'd2, b + 22);
        press(m_up);
        vectors++;
        if (mode !== 2'd1 || sel !== 2'd2 || step !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_up_enter: got mode=%0d sel=%0d step=%0d, required mode=1 sel=2 step=0", mode, sel, step);
        end
        wait_until(m_up + 12);
        vectors++;
        if (mode !== 2'd1 || sel !== 2'd1) begin
            miscompares++;
            $display("FAIL scan_up_wrap: got mode=%0d sel=%0d, required mode=1 sel=1", mode, sel);
        end
    endtask

    task automatic test_collision();
        m_down = cyc + 6;
        push_step(2'd1, m_down + 4);
        push_step(2'd0, m_down + 8);
        push_step(2'd3, m_down + 12);
        press(m_down);
        vectors++;
        if (mode !== 2'd2 || sel !== 2'd2) begin
            miscompares++;
            $display("FAIL scan_down_enter: got mode=%0d sel=%0d, required mode=2 sel=2", mode, sel);
        end
        wait_until(m_down + 10);
        press(m_pp);
        vectors++;
        if (m_pp != m_down + 16 || mode !== 2'd3 || sel !== 2'd3 || step !== 1'b0) begin
            miscompares++;
            $display("FAIL collision: got mode=%0d sel=%0d step=%0d at cycle %0d, required mode=3 sel=3 step=0 at cycle %0d",
                     mode, sel, step, m_pp, m_down + 16);
        end
    endtask

    task automatic test_ping_pong();
        logic [1:0] seq [6];
        int idx;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2;
        seq[3] = 2'd3; seq[4] = 2'd2; seq[5] = 2'd1;
        idx = 3;
        for (int i = 1; i <= 7; i++) begin
            idx = (idx + 1) % 6;
            push_step(seq[idx], m_pp + 4 * i);
        end
        wait_until(m_pp + 3);
        vectors++;
        if (sel !== 2'd3) begin miscompares++; $display("FAIL pp_hold: got sel=%0d, required 3", sel); end
        wait_until(m_pp + 28);
        vectors++;
        if (mode !== 2'd3 || sel !== 2'd2) begin
            miscompares++;
            $display("FAIL pp_end: got mode=%0d sel=%0d, required mode=3 sel=2", mode, sel);
        end
    endtask

    task automatic test_reset_mid_scan();
        rst = 1'b1;
        wait_edges(1);
        vectors++;
        if (sel !== 2'd0 || mode !== 2'd0 || step !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got sel=%0d mode=%0d step=%0d, required 0 0 0", sel, mode, step);
        end
        rst = 1'b0;
        wait_edges(12);
        vectors++;
        if (mode !== 2'd0 || sel !== 2'd2) begin
            miscompares++;
            $display("FAIL post_reset_manual: got mode=%0d sel=%0d, required mode=0 sel=2", mode, sel);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_steps: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_glitch();
        test_scan_up();
        test_collision();
        test_ping_pong();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Generates the 2-bit select that drives the board's 2-to-4 LED decoder.
- Synchronises and debounces the two select switches and one mode push-button.
- Either passes the switch value through (manual mode) or steps the select automatically at a prescaled rate: up, down, or ping-pong.
- Sits between the raw iCE40UP5K pad inputs and the decoder; the decoder's active-low LED outputs are unchanged.

Parameters:
- TICK_DIV, 12000000, clock cycles per auto-scan step (1 Hz at 12 MHz); legal range >= 2.
- DEBOUNCE_CYCLES, 120000, consecutive stable samples required before a synchronised input is accepted (10 ms at 12 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- sw  input  2  raw select switches, asynchronous to clk.
- mode_btn  input  1  raw mode push-button, active-high, asynchronous.
- sel  output  2  select to the decoder.
- mode  output  2  current mode: 0 MANUAL, 1 SCAN_UP, 2 SCAN_DOWN, 3 PING_PONG.
- step  output  1  one-cycle pulse in the cycle sel changes due to an auto-scan step.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. All state is sampled on the rising edge of clk.
- Reset values: sel=0, mode=MANUAL, step=0, prescaler=0, ping-pong direction=up.
  - Debounced outputs reset to 0; synchroniser flops reset to 0.
  - Reset asserted mid-operation overrides everything in that cycle.
- Synchronisation: each raw input passes through a 2-flop synchroniser.
- Debounce, per bit:
  - A counter increments while the synchronised value differs from the accepted value, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the accepted value takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Button edge: btn_press is a 1-cycle pulse on the accepted button's 0->1 transition. Release produces nothing.
- Mode FSM:
  - Each btn_press advances MANUAL -> SCAN_UP -> SCAN_DOWN -> PING_PONG -> MANUAL.
  - mode is registered and changes the cycle after btn_press.
  - Every mode change clears the prescaler and sets the ping-pong direction to up.
  - sel is held across the change; there is no jump.
- MANUAL:
  - sel follows the accepted switch pair, registered, one cycle after the accepted value changes.
  - step stays 0 and the prescaler is held at 0.
- Scan modes:
  - The prescaler counts 0..TICK_DIV-1 and wraps; tick is asserted when it equals TICK_DIV-1.
  - On tick, sel updates next edge and step=1 for that same edge's cycle.
  - The first step after entering a scan mode occurs TICK_DIV cycles after the mode change.
- Step rules:
  - SCAN_UP: sel+1 mod 4 (3 wraps to 0).
  - SCAN_DOWN: sel-1 mod 4 (0 wraps to 3).
  - PING_PONG: sequence 0,1,2,3,2,1,0,1... Direction flips to down when stepping into 3 and to up when stepping into 0. If entered with sel=3, the first step goes to 2 (at 3 the direction is forced down).
- Simultaneous btn_press and tick: the mode change wins. No step occurs, step=0, and the prescaler clears.
- Switch activity is ignored outside MANUAL. On re-entering MANUAL, sel takes the current accepted switch value one cycle after the mode change.
- Width rules: sel arithmetic is 2-bit modular. The prescaler is $clog2(TICK_DIV) bits and the debounce counters are $clog2(DEBOUNCE_CYCLES+1) bits; neither may overflow.

Decomposition:
- Shared package decoder_scan_pkg:
  - mode encodings MODE_MANUAL/MODE_SCAN_UP/MODE_SCAN_DOWN/MODE_PING_PONG as a 2-bit enum typedef;
  - DIR_UP/DIR_DOWN constants.
- Sub-module sync_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, din, dout): 2-flop synchroniser plus the debounce counter. Instantiated three times: sw[0], sw[1], mode_btn.
- The mode FSM, prescaler and sel stepping stay in the top module.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=4, DEBOUNCE_CYCLES=3.
- Reset/MANUAL: assert rst 2 cycles, then set sw=2'b10 held -> sel=0, mode=0, step=0 after reset; sel=2 exactly 2 sync + 3 debounce + 1 register cycles after the sw change; step never 1.
- Glitch rejection: in MANUAL with accepted sw=0, pulse sw[0] high for 2 cycles -> sel stays 0. Hold it 3+ cycles -> sel becomes 1.
- SCAN_UP wrap: from sel=2, one clean button press -> mode=1. Steps occur every 4 cycles, first at 4 cycles after the mode change. sel sequence 3,0,1, each with a 1-cycle step pulse.
- PING_PONG from 3: press through to mode=3 with sel=3 -> sel sequence 2,1,0,1,2,3,2, step pulses every 4 cycles.
- Collision and reset mid-scan:
  - Time btn_press to coincide with tick in SCAN_DOWN -> mode=3, sel unchanged, step=0, next step 4 cycles later.
  - Assert rst during PING_PONG -> sel=0, mode=0 on the following cycle.
